// File: rtl/pacman_pkg.sv
// pacman_pkg: shared ghost-mode type and scoring constants
package pacman_pkg;
  typedef enum logic [1:0] {
    GM_IDLE    = 2'd0,
    GM_SCATTER = 2'd1,
    GM_CHASE   = 2'd2,
    GM_FRIGHT  = 2'd3
  } ghost_mode_t;
  localparam logic [10:0] GHOST_BASE_POINTS = 11'd200;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: tick-enabled counter with clear, load and saturation at lim
module frame_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             tick,
  input  logic [CNT_W-1:0] ld_val,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : ld ? ld_val : (tick && cnt_q != lim) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: scatter/chase/frightened mode sequencer on the frame-tick time base
module ghost_mode_scheduler
  import pacman_pkg::*;
#(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int NUM_PHASES     = 4,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int FLASH_PERIOD   = 14,
  parameter int CNT_W          = 11
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        isIntro,
  input  logic        restart,
  input  logic        replay,
  input  logic        power_pellet,
  input  logic        ghost_eaten,
  output ghost_mode_t ghost_mode,
  output logic        reverse,
  output logic        fright_flash,
  output logic        points_valid,
  output logic [10:0] ghost_points
);
  localparam int PW = NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1;
  localparam int FW = FLASH_PERIOD > 1 ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [CNT_W-1:0] S_LIM = CNT_W'(SCATTER_FRAMES - 1);
  localparam logic [CNT_W-1:0] C_LIM = CNT_W'(CHASE_FRAMES - 1);
  localparam logic [CNT_W-1:0] F_LIM = CNT_W'(FRIGHT_FRAMES - 1);
  localparam logic [CNT_W-1:0] F_START = CNT_W'(FRIGHT_FRAMES - FLASH_FRAMES);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PHASES - 1);
  localparam logic [FW-1:0] FP_LAST = FW'(FLASH_PERIOD - 1);
  ghost_mode_t mode_q, mode_d, saved_mode_q, saved_mode_d;
  logic [CNT_W-1:0] saved_cnt_q, saved_cnt_d, p_cnt, f_cnt;
  logic [PW-1:0] phase_q, phase_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [1:0] eat_q, eat_d;
  logic rev_q, rev_d, flash_q, flash_d, pv_q, pv_d;
  logic [10:0] pts_q, pts_d;
  logic p_clr, p_ld, p_tick, f_clr, f_tick;
  frame_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk(Clk), .rst_n(Reset_n), .clr(p_clr), .ld(p_ld), .tick(p_tick),
    .ld_val(saved_cnt_q), .lim(mode_q == GM_SCATTER ? S_LIM : C_LIM), .cnt(p_cnt)
  );
  frame_timer #(.CNT_W(CNT_W)) u_fright_timer (
    .clk(Clk), .rst_n(Reset_n), .clr(f_clr), .ld(1'b0), .tick(f_tick),
    .ld_val('0), .lim(F_LIM), .cnt(f_cnt)
  );
  always_comb begin
    mode_d = mode_q;
    saved_mode_d = saved_mode_q;
    saved_cnt_d = saved_cnt_q;
    phase_d = phase_q;
    eat_d = eat_q;
    fcnt_d = fcnt_q;
    flash_d = flash_q;
    rev_d = 1'b0;
    pv_d = 1'b0;
    pts_d = pts_q;
    p_clr = 1'b0;
    p_ld = 1'b0;
    p_tick = 1'b0;
    f_clr = 1'b0;
    f_tick = 1'b0;
    if (isIntro || restart || replay) begin
      mode_d = isIntro ? GM_IDLE : GM_SCATTER;
      saved_mode_d = GM_IDLE;
      saved_cnt_d = '0;
      phase_d = '0;
      eat_d = '0;
      fcnt_d = '0;
      flash_d = 1'b0;
      pts_d = '0;
      p_clr = 1'b1;
      f_clr = 1'b1;
    end else if (power_pellet && mode_q != GM_IDLE) begin
      saved_mode_d = mode_q == GM_FRIGHT ? saved_mode_q : mode_q;
      saved_cnt_d = mode_q == GM_FRIGHT ? saved_cnt_q : p_cnt;
      rev_d = mode_q != GM_FRIGHT;
      mode_d = GM_FRIGHT;
      eat_d = '0;
      fcnt_d = '0;
      flash_d = 1'b0;
      f_clr = 1'b1;
    end else begin
      if (ghost_eaten && mode_q == GM_FRIGHT) begin
        pv_d = 1'b1;
        pts_d = GHOST_BASE_POINTS << eat_q;
        eat_d = eat_q + {1'b0, eat_q != 2'd3};
      end
      if (frame_tick && mode_q == GM_SCATTER) begin
        p_tick = 1'b1;
        if (p_cnt == S_LIM) begin
          mode_d = GM_CHASE;
          p_clr = 1'b1;
          rev_d = 1'b1;
        end
      end else if (frame_tick && mode_q == GM_CHASE) begin
        p_tick = 1'b1;
        if (p_cnt == C_LIM && phase_q != P_LAST) begin
          phase_d = phase_q + 1'b1;
          mode_d = GM_SCATTER;
          p_clr = 1'b1;
          rev_d = 1'b1;
        end
      end else if (frame_tick && mode_q == GM_FRIGHT) begin
        if (f_cnt == F_LIM) begin
          mode_d = saved_mode_q;
          p_ld = 1'b1;
          f_clr = 1'b1;
          eat_d = '0;
          fcnt_d = '0;
          flash_d = 1'b0;
        end else begin
          f_tick = 1'b1;
          if (f_cnt >= F_START) begin
            fcnt_d = fcnt_q == FP_LAST ? '0 : fcnt_q + 1'b1;
            flash_d = flash_q ^ (fcnt_q == FP_LAST);
          end
        end
      end
    end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      mode_q <= GM_IDLE;
      saved_mode_q <= GM_IDLE;
      saved_cnt_q <= '0;
      phase_q <= '0;
      eat_q <= '0;
      fcnt_q <= '0;
      flash_q <= 1'b0;
      rev_q <= 1'b0;
      pv_q <= 1'b0;
      pts_q <= '0;
    end else begin
      mode_q <= mode_d;
      saved_mode_q <= saved_mode_d;
      saved_cnt_q <= saved_cnt_d;
      phase_q <= phase_d;
      eat_q <= eat_d;
      fcnt_q <= fcnt_d;
      flash_q <= flash_d;
      rev_q <= rev_d;
      pv_q <= pv_d;
      pts_q <= pts_d;
    end
  assign ghost_mode = mode_q;
  assign reverse = rev_q;
  assign fright_flash = flash_q;
  assign points_valid = pv_q;
  assign ghost_points = pts_q;
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler: directed scoreboard bench for ghost_mode_scheduler
module tb_ghost_mode_scheduler;
  import pacman_pkg::*;
  typedef struct packed {
    logic [1:0] m;
    logic r;
    logic f;
    logic pv;
    logic [10:0] pts;
  } exp_t;
  localparam logic [1:0] ID = 2'd0, SC = 2'd1, CH = 2'd2, FR = 2'd3;
  localparam logic [5:0] NO = 6'b000000, T = 6'b100000, IN = 6'b010000, RS = 6'b001000;
  localparam logic [5:0] RP = 6'b000100, PP = 6'b000010, GE = 6'b000001;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic frame_tick = 1'b0, isIntro = 1'b0, restart = 1'b0, replay = 1'b0;
  logic power_pellet = 1'b0, ghost_eaten = 1'b0;
  ghost_mode_t ghost_mode;
  logic reverse, fright_flash, points_valid;
  logic [10:0] ghost_points;
  exp_t exp_q[$];
  string tag_q[$];
  string tag;
  exp_t e;
  string t;
  int n_vec = 0, n_miss = 0;
  ghost_mode_scheduler #(
    .SCATTER_FRAMES(4), .CHASE_FRAMES(6), .NUM_PHASES(2), .FRIGHT_FRAMES(5),
    .FLASH_FRAMES(2), .FLASH_PERIOD(1), .CNT_W(11)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .isIntro(isIntro),
    .restart(restart), .replay(replay), .power_pellet(power_pellet),
    .ghost_eaten(ghost_eaten), .ghost_mode(ghost_mode), .reverse(reverse),
    .fright_flash(fright_flash), .points_valid(points_valid), .ghost_points(ghost_points)
  );
  always #5 Clk = ~Clk;
  task automatic push(input logic [1:0] m, input logic r, input logic f, input logic pv, input logic [10:0] pts);
    exp_t x;
    x = '{m, r, f, pv, pts};
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask
  task automatic cyc(input logic [5:0] in, input logic [1:0] m, input logic r, input logic f, input logic pv, input logic [10:0] pts);
    @(negedge Clk);
    {frame_tick, isIntro, restart, replay, power_pellet, ghost_eaten} = in;
    @(posedge Clk);
    push(m, r, f, pv, pts);
  endtask
  task automatic rst_step(input logic v);
    @(negedge Clk);
    Reset_n = v;
    {frame_tick, isIntro, restart, replay, power_pellet, ghost_eaten} = NO;
    @(posedge Clk);
    push(ID, 1'b0, 1'b0, 1'b0, 11'd0);
  endtask
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec++;
      if (2'(ghost_mode) != e.m || reverse != e.r || fright_flash != e.f ||
          points_valid != e.pv || (e.pv && ghost_points != e.pts)) begin
        n_miss++;
        $display("FAIL %s vec %0d: got mode=%0d rev=%b flash=%b pv=%b pts=%0d, want mode=%0d rev=%b flash=%b pv=%b pts=%0d",
                 t, n_vec, 2'(ghost_mode), reverse, fright_flash, points_valid, ghost_points,
                 e.m, e.r, e.f, e.pv, e.pts);
      end
    end
  end
  initial begin
    tag = "reset";
    rst_step(1'b0);
    rst_step(1'b0);
    rst_step(1'b1);
    tag = "restart_seq";
    cyc(RS, SC, 0, 0, 0, 0);
    for (int k = 1; k <= 30; k++)
      cyc(T, (k < 4 || (k >= 10 && k < 14)) ? SC : CH, k == 4 || k == 10 || k == 14, 0, 0, 0);
    tag = "eat_in_chase";
    cyc(GE, CH, 0, 0, 0, 0);
    tag = "pellet_resume";
    cyc(RP, SC, 0, 0, 0, 0);
    cyc(T, SC, 0, 0, 0, 0);
    cyc(T, SC, 0, 0, 0, 0);
    cyc(PP, FR, 1, 0, 0, 0);
    cyc(NO, FR, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      cyc(T, FR, 0, k == 4, 0, 0);
    cyc(T, SC, 0, 0, 0, 0);
    cyc(T, SC, 0, 0, 0, 0);
    cyc(T, CH, 1, 0, 0, 0);
    tag = "eat_chain";
    cyc(PP, FR, 1, 0, 0, 0);
    cyc(GE, FR, 0, 0, 1, 200);
    cyc(GE, FR, 0, 0, 1, 400);
    cyc(GE, FR, 0, 0, 1, 800);
    cyc(GE, FR, 0, 0, 1, 1600);
    cyc(GE, FR, 0, 0, 1, 1600);
    cyc(PP, FR, 0, 0, 0, 0);
    cyc(GE, FR, 0, 0, 1, 200);
    tag = "pellet_beats_eat";
    cyc(PP | GE, FR, 0, 0, 0, 0);
    cyc(GE, FR, 0, 0, 1, 200);
    tag = "eat_at_expiry";
    for (int k = 1; k <= 4; k++)
      cyc(T, FR, 0, k == 4, 0, 0);
    cyc(T | GE, CH, 0, 0, 1, 400);
    tag = "replay_in_fright";
    for (int k = 1; k <= 6; k++)
      cyc(T, k < 6 ? CH : SC, k == 6, 0, 0, 0);
    cyc(PP, FR, 1, 0, 0, 0);
    cyc(RP | PP, SC, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      cyc(T, k < 4 ? SC : CH, k == 4, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      cyc(T, k < 6 ? CH : SC, k == 6, 0, 0, 0);
    tag = "intro_idle";
    cyc(IN | T | PP, ID, 0, 0, 0, 0);
    cyc(IN | RS, ID, 0, 0, 0, 0);
    cyc(IN | GE | T, ID, 0, 0, 0, 0);
    cyc(T | PP, ID, 0, 0, 0, 0);
    cyc(GE | T, ID, 0, 0, 0, 0);
    tag = "reset_mid_fright";
    cyc(RS, SC, 0, 0, 0, 0);
    cyc(PP, FR, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++)
      cyc(T, FR, 0, 0, 0, 0);
    cyc(T | GE, FR, 0, 1, 1, 200);
    rst_step(1'b0);
    rst_step(1'b1);
    cyc(T | PP, ID, 0, 0, 0, 0);
    cyc(RS, SC, 0, 0, 0, 0);
    cyc(T, SC, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
